// File: rtl/tx_pkg.sv
// Shared widths and the monitor entry layout for the register-stage monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tx_pkg;

  localparam int WIDTH    = 8;
  localparam int MON_TS_W = 16;

  typedef struct packed {
    logic [MON_TS_W-1:0] ts;
    logic [WIDTH-1:0]    data;
  } mon_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic first-word-fall-through FIFO with synchronous flush.
// Latency: write at edge N is visible on dout after edge N; pop at edge M presents the next head after edge M.
// Backpressure: push is taken when not full, or when full with a pop in the same cycle; otherwise ignored.
//
// Ports: clk/reset (async, active-high), flush (sync empty, beats push/pop),
//        push/din, pop, dout (head, zero when empty), full, empty, count.
module sync_fifo #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DATA_W-1:0]        din,
  input  logic                     pop,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign do_pop  = pop && !empty;
  // A pop frees the head slot this edge, so a push into a full queue still fits.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: the head is masked to zero whenever empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/reg_delta_fifo.sv
// Watches the register output bus, queues each value change with a timestamp, drains via valid/ready.
// Latency: change sampled at edge N appears at the head after edge N when the queue was empty.
// Backpressure: out_ready low holds the head stable; changes arriving at a full queue are dropped and counted.
//
// Ports: clk, reset (async, active-high), outa (monitored bus), capture_en (sample enable),
//        clear (sync flush of queue, primed flag and drop counter), out_valid/out_ready/out_data/out_ts
//        (drain port), count (occupancy), drop_cnt (saturating dropped-change count).
module reg_delta_fifo #(
  parameter int WIDTH = tx_pkg::WIDTH,
  parameter int DEPTH = 8,
  parameter int TS_W  = tx_pkg::MON_TS_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       outa,
  input  logic                   capture_en,
  input  logic                   clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [TS_W-1:0]        out_ts,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             drop_cnt
);

  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic [WIDTH-1:0] data;
  } entry_t;

  logic [TS_W-1:0]  ts;
  logic [WIDTH-1:0] prev;
  logic             primed;
  logic             change;
  logic             pop;
  logic             full;
  logic             empty;
  entry_t           push_entry;
  entry_t           head_entry;

  // Unprimed means there is no previous sample, so the first capture always counts as a change.
  assign change = capture_en && (!primed || (outa != prev));
  assign pop    = out_valid && out_ready;

  assign push_entry.ts   = ts;
  assign push_entry.data = outa;

  sync_fifo #(
    .DATA_W ($bits(entry_t)),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (clear),
    .push  (change && !clear),
    .din   (push_entry),
    .pop   (pop && !clear),
    .dout  (head_entry),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign out_valid = !empty;
  assign out_data  = head_entry.data;
  assign out_ts    = head_entry.ts;

  // Free-running; deliberately unaffected by clear so timestamps stay monotonic across flushes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ts <= '0;
    else       ts <= ts + TS_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev   <= '0;
      primed <= 1'b0;
    end else if (clear) begin
      prev   <= '0;
      primed <= 1'b0;
    end else if (capture_en) begin
      prev   <= outa;
      primed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (clear) begin
      drop_cnt <= '0;
    end else if (change && full && !pop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_reg_delta_fifo.sv
// Directed bench for reg_delta_fifo with a queue scoreboard of expected entries.
// Latency: n/a.
// Backpressure: exercises held, full, full-with-pop and flushed queues.
module tb_reg_delta_fifo;
  import tx_pkg::*;

  logic       clk;
  logic       reset;
  logic [7:0] outa;
  logic       capture_en;
  logic       clear;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [15:0] out_ts;
  logic [3:0] count;
  logic [7:0] drop_cnt;

  reg_delta_fifo #(.WIDTH(8), .DEPTH(8), .TS_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .outa       (outa),
    .capture_en (capture_en),
    .clear      (clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ts     (out_ts),
    .count      (count),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state, advanced alongside the stimulus.
  mon_entry_t  q[$];
  logic [15:0] m_ts;
  logic [7:0]  m_prev;
  bit          m_primed;
  int          m_drop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ts     = '0;
    m_prev   = '0;
    m_primed = 1'b0;
    m_drop   = 0;
  endtask

  // Drive one cycle of stimulus, update the scoreboard for the coming edge, then check after it.
  task automatic cycle(input bit rdy, input bit cap, input logic [7:0] val, input bit clr);
    bit         ev;
    bit         pop;
    mon_entry_t e;
    out_ready  = rdy;
    capture_en = cap;
    outa       = val;
    clear      = clr;
    ev  = cap && (!m_primed || (val != m_prev));
    pop = (q.size() != 0) && rdy;
    if (clr) begin
      q.delete();
      m_drop   = 0;
      m_primed = 1'b0;
      m_prev   = '0;
    end else begin
      if (pop) void'(q.pop_front());
      if (ev) begin
        if (q.size() < 8) begin
          e.ts   = m_ts;
          e.data = val;
          q.push_back(e);
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
      if (cap) begin
        m_prev   = val;
        m_primed = 1'b1;
      end
    end
    m_ts++;
    @(posedge clk);
    #1;
    check("count", 32'(count), 32'(q.size()));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("head_data", 32'(out_data), 32'(q[0].data));
      check("head_ts", 32'(out_ts), 32'(q[0].ts));
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    reset      = 1'b1;
    outa       = '0;
    capture_en = 1'b0;
    clear      = 1'b0;
    out_ready  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state.
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_ts", 32'(out_ts), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);

    // First capture after reset: one idle edge, then 0x00 captured while ts = 1.
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    check("first_valid", 32'(out_valid), 32'd1);
    check("first_ts", 32'(out_ts), 32'd1);
    check("first_data", 32'(out_data), 32'h00);
    drain(1);

    // Unchanged input produces a single entry; then two further changes.
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'h5A, 1'b0);
    check("hold_count", 32'(count), 32'd1);
    cycle(1'b0, 1'b1, 8'hA5, 1'b0);
    cycle(1'b0, 1'b1, 8'hA5, 1'b0);
    cycle(1'b0, 1'b1, 8'h3C, 1'b0);
    check("seq_count", 32'(count), 32'd3);
    drain(3);

    // Overflow: twelve distinct values into an eight-deep queue.
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
    check("ovf_count", 32'(count), 32'd8);
    check("ovf_drop", 32'(drop_cnt), 32'd4);
    check("ovf_head", 32'(out_data), 32'h10);

    // Full with a simultaneous pop: occupancy holds, no drop, new value at the tail.
    cycle(1'b1, 1'b1, 8'h77, 1'b0);
    check("fullpop_count", 32'(count), 32'd8);
    check("fullpop_drop", 32'(drop_cnt), 32'd4);
    drain(7);
    check("tail_data", 32'(out_data), 32'h77);
    drain(1);

    // Clear with five queued entries and a same-cycle change.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'(8'h20 + i), 1'b0);
    cycle(1'b1, 1'b1, 8'h30, 1'b1);
    check("clr_count", 32'(count), 32'd0);
    check("clr_drop", 32'(drop_cnt), 32'd0);
    cycle(1'b0, 1'b1, 8'h24, 1'b0);
    check("clr_repush", 32'(count), 32'd1);
    drain(1);

    // Asynchronous reset between edges discards queued entries without a clock.
    cycle(1'b0, 1'b1, 8'h41, 1'b0);
    cycle(1'b0, 1'b1, 8'h42, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    cycle(1'b0, 1'b1, 8'h42, 1'b0);
    check("arst_repush", 32'(count), 32'd1);
    drain(1);

    // Timestamp wrap: idle up to ts = 0xFFFE, then capture across the wrap.
    capture_en = 1'b0;
    out_ready  = 1'b1;
    while (m_ts != 16'hFFFE) begin
      @(posedge clk);
      #1;
      m_ts++;
    end
    cycle(1'b0, 1'b1, 8'hC1, 1'b0);
    cycle(1'b0, 1'b1, 8'hC2, 1'b0);
    cycle(1'b0, 1'b1, 8'hC3, 1'b0);
    check("wrap_ts0", 32'(out_ts), 32'hFFFE);
    drain(1);
    check("wrap_ts1", 32'(out_ts), 32'hFFFF);
    drain(1);
    check("wrap_ts2", 32'(out_ts), 32'h0000);
    check("wrap_data2", 32'(out_data), 32'hC3);
    drain(1);
    check("end_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
